// File: rtl/rv32i_amo_seq.sv
// Multi-cycle read-modify-write sequencer for RV32A word AMOs (IDLE -> READ x RD_LAT -> WRITE).
// Define RV32I_AMO_MINMAX_EN to add AMOMIN/AMOMAX/AMOMINU/AMOMAXU; otherwise those encodings raise amo_err.
module rv32i_amo_seq #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_amo,
    input  logic [2:0]  funct3,
    input  logic [4:0]  funct5,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        rd_we,
    output logic [31:0] rd_wdata,
    output logic        amo_err
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, opnd_q, old_q;
    logic [4:0]  op_q;
    logic [2:0]  cnt_q;
    logic        legal_op, accept, err_nxt, last_read;
    logic [31:0] amo_result;

    always_comb begin
        legal_op = 1'b0;
        case (funct5)
            5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100: legal_op = 1'b1;
`ifdef RV32I_AMO_MINMAX_EN
            5'b10000, 5'b10100, 5'b11000, 5'b11100:           legal_op = 1'b1;
`endif
            default:                                          legal_op = 1'b0;
        endcase
    end

    assign accept    = (state == IDLE) && is_amo && legal_op &&
                       (funct3 == 3'b010) && (rs1_data[1:0] == 2'b00);
    assign err_nxt   = (state == IDLE) && is_amo && !accept;
    assign last_read = (cnt_q == 3'(RD_LAT - 1));

    // Ties in the min/max compares keep the old memory value.
    always_comb begin
        amo_result = old_q;
        case (op_q)
            5'b00000: amo_result = old_q + opnd_q;
            5'b00001: amo_result = opnd_q;
            5'b00100: amo_result = old_q ^ opnd_q;
            5'b01000: amo_result = old_q | opnd_q;
            5'b01100: amo_result = old_q & opnd_q;
`ifdef RV32I_AMO_MINMAX_EN
            5'b10000: amo_result = ($signed(old_q) <= $signed(opnd_q)) ? old_q : opnd_q;
            5'b10100: amo_result = ($signed(old_q) >= $signed(opnd_q)) ? old_q : opnd_q;
            5'b11000: amo_result = (old_q <= opnd_q) ? old_q : opnd_q;
            5'b11100: amo_result = (old_q >= opnd_q) ? old_q : opnd_q;
`endif
            default:  amo_result = old_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            opnd_q  <= '0;
            old_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            amo_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            amo_err <= err_nxt;
            if (accept) begin
                addr_q <= rs1_data;
                opnd_q <= rs2_data;
                op_q   <= funct5;
                cnt_q  <= '0;
            end
            if (state == READ) begin
                if (last_read)
                    old_q <= mem_rdata;
                else
                    cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Outputs are zero outside the cycles that own the memory port or register write.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        busy      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_we     = 1'b0;
        rd_wdata  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                stall    = 1'b1;
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (last_read)
                    state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = amo_result;
                rd_we     = 1'b1;
                rd_wdata  = old_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32i_amo_seq.sv
// Directed bench for rv32i_amo_seq: one instance with RD_LAT=1, one with RD_LAT=3, each with a word memory model.
module tb_rv32i_amo_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_amo1, is_amo3;
    logic [2:0]  funct3;
    logic [4:0]  funct5;
    logic [31:0] rs1_data, rs2_data;

    logic        stall1, busy1, mem_read1, mem_write1, rd_we1, amo_err1;
    logic [31:0] mem_addr1, mem_wdata1, rd_wdata1, mem_rdata1;
    logic        stall3, busy3, mem_read3, mem_write3, rd_we3, amo_err3;
    logic [31:0] mem_addr3, mem_wdata3, rd_wdata3, mem_rdata3;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic        pre_we1, pre_we3;
    logic [31:0] pre_addr, pre_data;

    int checks = 0;
    int errors = 0;
    int rdwe_cnt1 = 0;
    int rdwe_snap;

    always #5 clk = ~clk;

    rv32i_amo_seq #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .is_amo(is_amo1), .funct3(funct3), .funct5(funct5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_rdata(mem_rdata1),
        .stall(stall1), .busy(busy1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .rd_we(rd_we1), .rd_wdata(rd_wdata1),
        .amo_err(amo_err1)
    );

    rv32i_amo_seq #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .is_amo(is_amo3), .funct3(funct3), .funct5(funct5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_rdata(mem_rdata3),
        .stall(stall3), .busy(busy3), .mem_read(mem_read3), .mem_write(mem_write3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .rd_we(rd_we3), .rd_wdata(rd_wdata3),
        .amo_err(amo_err3)
    );

    assign mem_rdata1 = mem1[mem_addr1[7:2]];
    assign mem_rdata3 = mem3[mem_addr3[7:2]];

    // Memory models: DUT writes take priority over bench preloads.
    always @(posedge clk) begin
        if (mem_write1)
            mem1[mem_addr1[7:2]] <= mem_wdata1;
        else if (pre_we1)
            mem1[pre_addr[7:2]] <= pre_data;
        if (mem_write3)
            mem3[mem_addr3[7:2]] <= mem_wdata3;
        else if (pre_we3)
            mem3[pre_addr[7:2]] <= pre_data;
        if (rd_we1)
            rdwe_cnt1 <= rdwe_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input bit which3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        if (which3) pre_we3 = 1'b1; else pre_we1 = 1'b1;
        @(negedge clk);
        pre_we1 = 1'b0;
        pre_we3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; is_amo1 = 1'b0; is_amo3 = 1'b0;
        funct3 = 3'b010; funct5 = 5'b00000; rs1_data = '0; rs2_data = '0;
        pre_we1 = 1'b0; pre_we3 = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 64; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end

        // Reset state
        tick(); tick();
        check("rst_stall", {31'd0, stall1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_amo_err", {31'd0, amo_err1}, 32'd0);
        check("rst_mem_addr", mem_addr1, 32'd0);
        check("rst_rd_wdata", rd_wdata1, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Test 1: amoadd mem[0x40]=5 + 3, RD_LAT=1, three cycles
        preload(1'b0, 32'h40, 32'd5);
        funct3 = 3'b010; funct5 = 5'b00000; rs1_data = 32'h40; rs2_data = 32'd3; is_amo1 = 1'b1;
        #1;
        check("t1_idle_stall", {31'd0, stall1}, 32'd1);
        check("t1_idle_busy", {31'd0, busy1}, 32'd0);
        tick();
        check("t1_read_stall", {31'd0, stall1}, 32'd1);
        check("t1_read_en", {31'd0, mem_read1}, 32'd1);
        check("t1_read_addr", mem_addr1, 32'h40);
        rs2_data = 32'h63;
        tick();
        check("t1_wr_stall", {31'd0, stall1}, 32'd0);
        check("t1_wr_en", {31'd0, mem_write1}, 32'd1);
        check("t1_wr_rd_en", {31'd0, mem_read1}, 32'd0);
        check("t1_wdata", mem_wdata1, 32'd8);
        check("t1_rd_we", {31'd0, rd_we1}, 32'd1);
        check("t1_rd_wdata", rd_wdata1, 32'd5);
        is_amo1 = 1'b0;
        tick();
        check("t1_idle_after", {31'd0, busy1}, 32'd0);
        check("t1_mem", mem1[16], 32'd8);

        // Test 2: amoadd wraps past 2^32
        preload(1'b0, 32'h40, 32'hFFFF_FFFF);
        funct5 = 5'b00000; rs1_data = 32'h40; rs2_data = 32'd2; is_amo1 = 1'b1;
        tick();
        tick();
        check("t2_wdata", mem_wdata1, 32'h0000_0001);
        check("t2_rd_wdata", rd_wdata1, 32'hFFFF_FFFF);
        is_amo1 = 1'b0;
        tick();
        check("t2_mem", mem1[16], 32'h0000_0001);

        // Test 3: misaligned amoswap retires with an error pulse
        @(negedge clk);
        funct5 = 5'b00001; rs1_data = 32'h42; rs2_data = 32'd7; is_amo1 = 1'b1;
        #1;
        check("t3_stall", {31'd0, stall1}, 32'd0);
        check("t3_read", {31'd0, mem_read1}, 32'd0);
        tick();
        check("t3_err", {31'd0, amo_err1}, 32'd1);
        check("t3_read2", {31'd0, mem_read1}, 32'd0);
        check("t3_write", {31'd0, mem_write1}, 32'd0);
        is_amo1 = 1'b0;
        tick();
        check("t3_err_clear", {31'd0, amo_err1}, 32'd0);

        // Illegal funct3 takes the same error path
        @(negedge clk);
        funct3 = 3'b000; funct5 = 5'b00000; rs1_data = 32'h40; is_amo1 = 1'b1;
        #1;
        check("f3_stall", {31'd0, stall1}, 32'd0);
        tick();
        check("f3_err", {31'd0, amo_err1}, 32'd1);
        check("f3_busy", {31'd0, busy1}, 32'd0);
        is_amo1 = 1'b0; funct3 = 3'b010;
        tick();

        // Test 4: RD_LAT=3 amoor, five cycles total
        preload(1'b1, 32'h40, 32'h0F0);
        funct5 = 5'b01000; rs1_data = 32'h40; rs2_data = 32'h00F; is_amo3 = 1'b1;
        #1;
        check("t4_idle_stall", {31'd0, stall3}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t4_read%0d", c), {30'd0, stall3, mem_read3}, 32'd3);
        end
        tick();
        check("t4_wr_en", {30'd0, mem_write3, mem_read3}, 32'd2);
        check("t4_wdata", mem_wdata3, 32'h0FF);
        check("t4_rd_wdata", rd_wdata3, 32'h0F0);
        check("t4_wr_stall", {31'd0, stall3}, 32'd0);
        is_amo3 = 1'b0;
        tick();
        check("t4_mem", mem3[16], 32'h0FF);
        check("t4_busy", {31'd0, busy3}, 32'd0);

        // Test 5: reset during READ abandons the AMO
        rdwe_snap = rdwe_cnt1;
        @(negedge clk);
        funct5 = 5'b00100; rs1_data = 32'h40; rs2_data = 32'hFF; is_amo1 = 1'b1;
        tick();
        check("t5_read", {31'd0, mem_read1}, 32'd1);
        rst_n = 1'b0; is_amo1 = 1'b0;
        #1;
        check("t5_rst_outs", {26'd0, stall1, busy1, mem_read1, mem_write1, rd_we1, amo_err1}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        check("t5_no_rdwe", rdwe_cnt1, rdwe_snap);
        check("t5_mem", mem1[16], 32'h0000_0001);

        // Test 6: amomin, signed compare keeps the negative old value
        preload(1'b0, 32'h40, 32'hFFFF_FFFE);
        funct5 = 5'b10000; rs1_data = 32'h40; rs2_data = 32'd1; is_amo1 = 1'b1;
        #1;
`ifdef RV32I_AMO_MINMAX_EN
        check("t6_stall", {31'd0, stall1}, 32'd1);
        tick();
        tick();
        check("t6_wdata", mem_wdata1, 32'hFFFF_FFFE);
        check("t6_rd_wdata", rd_wdata1, 32'hFFFF_FFFE);
        is_amo1 = 1'b0;
        tick();
`else
        check("t6_stall", {31'd0, stall1}, 32'd0);
        tick();
        check("t6_err", {31'd0, amo_err1}, 32'd1);
        check("t6_read", {31'd0, mem_read1}, 32'd0);
        is_amo1 = 1'b0;
        tick();
`endif
        check("t6_mem", mem1[16], 32'hFFFF_FFFE);

        // amoand on the same word
        @(negedge clk);
        funct5 = 5'b01100; rs1_data = 32'h40; rs2_data = 32'h0000_FF0F; is_amo1 = 1'b1;
        tick();
        tick();
        check("and_wdata", mem_wdata1, 32'h0000_FF0E);
        check("and_rd_wdata", rd_wdata1, 32'hFFFF_FFFE);
        is_amo1 = 1'b0;
        tick();
        check("and_mem", mem1[16], 32'h0000_FF0E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
